// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg: opcode, ALUOp, mux-select and state encodings for the multi-cycle control unit
package multicycle_ctrl_fsm_pkg;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASS  = 2'b11;
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_REG   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;
    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [2:0] F3_BEQ      = 3'b000;
    localparam logic [2:0] F3_BNE      = 3'b001;
    localparam logic [2:0] F3_SRA      = 3'b101;
    typedef enum logic [3:0] {
        ST_RESET = 4'd0, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_WB_ALU, ST_ADDR,
        ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_BRANCH, ST_LUI, ST_TRAP
    } state_t;
    function automatic state_t dispatch(logic [6:0] opc);
        case (opc)
            OPC_RTYPE:           return ST_EXEC_R;
            OPC_ITYPE:           return ST_EXEC_I;
            OPC_LOAD, OPC_STORE: return ST_ADDR;
            OPC_BRANCH:          return ST_BRANCH;
            OPC_LUI:             return ST_LUI;
            default:             return ST_TRAP;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_ctrl_fsm_branch_eval.sv
// ctrl_branch_eval: branch-taken and illegal-funct3 decode from funct3 and the ALU zero flag
module ctrl_branch_eval
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    output logic       take_o,
    output logic       illegal_o
);
    always_comb begin
        take_o    = (funct3_i == F3_BEQ) ? zero_i : (funct3_i == F3_BNE) ? !zero_i : 1'b0;
        illegal_o = funct3_i[2:1] != 2'b00;
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multi-cycle RV32 core with memory stall and timeout trap
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic       mem_to_reg_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       alu_f7_en_o,
    output logic       trap_o,
    output logic [3:0] state_o
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          waiting, timed_out, br_take, br_illegal;
    ctrl_branch_eval u_branch_eval (
        .funct3_i  (funct3_i),
        .zero_i    (zero_i),
        .take_o    (br_take),
        .illegal_o (br_illegal)
    );
    assign waiting   = state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
    // ready in the same cycle as the limit still completes normally
    assign timed_out = (MEM_TIMEOUT != 0) && waiting && !mem_ready_i && (wait_cnt == CW'(MEM_TIMEOUT));
    assign state_o   = state;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_RESET;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= (state_nx != state || mem_ready_i || !waiting) ? '0 : wait_cnt + CW'(1);
        end
    end
    always_comb begin
        state_nx     = state;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_REG;
        alu_op_o     = ALUOP_ADD;
        alu_f7_en_o  = 1'b0;
        trap_o       = 1'b0;
        case (state)
            ST_RESET: state_nx = ST_FETCH;
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                state_nx    = mem_ready_i ? ST_DECODE : timed_out ? ST_TRAP : ST_FETCH;
            end
            ST_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                state_nx    = dispatch(opcode_i);
            end
            ST_EXEC_R: begin
                alu_src_a_o = SRC_A_REG;
                alu_op_o    = ALUOP_FUNCT;
                alu_f7_en_o = 1'b1;
                state_nx    = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALUOP_FUNCT;
                alu_f7_en_o = funct3_i == F3_SRA;
                state_nx    = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                reg_write_o = 1'b1;
                state_nx    = ST_FETCH;
            end
            ST_ADDR: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_IMM;
                state_nx    = (opcode_i == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                state_nx   = mem_ready_i ? ST_WB_MEM : timed_out ? ST_TRAP : ST_MEM_RD;
            end
            ST_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_nx     = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                state_nx    = mem_ready_i ? ST_FETCH : timed_out ? ST_TRAP : ST_MEM_WR;
            end
            ST_BRANCH: begin
                alu_src_a_o = SRC_A_REG;
                alu_op_o    = ALUOP_SUB;
                pc_src_o    = 1'b1;
                pc_write_o  = br_take && !br_illegal;
                state_nx    = br_illegal ? ST_TRAP : ST_FETCH;
            end
            ST_LUI: begin
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALUOP_PASS;
                reg_write_o = 1'b1;
                state_nx    = ST_FETCH;
            end
            ST_TRAP: trap_o = 1'b1;
            default: state_nx = ST_TRAP;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: random and directed instruction streams checked against an instruction-level model
module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_fsm_pkg::*;
    localparam int TO = 16;
    typedef struct packed {
        logic mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg;
        logic [1:0] src_a, src_b, alu_op;
        logic f7_en, trap;
        logic [3:0] state;
    } outs_t;
    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, ready = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, mem_to_reg_o;
    logic alu_f7_en_o, trap_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [3:0] state_o;
    int checks = 0, errors = 0, n;
    logic started = 1'b0;
    state_t cur = ST_RESET;
    state_t plan[$];
    int wcnt = 0;
    logic [6:0] legal[6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3), .zero_i(zero),
        .mem_ready_i(ready), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .alu_f7_en_o(alu_f7_en_o),
        .trap_o(trap_o), .state_o(state_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        return {mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o,
                mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, alu_f7_en_o, trap_o, state_o};
    endfunction

    // what each step of an instruction must drive, straight from the control table
    function automatic outs_t expect_outs(state_t s, logic rdy, logic z, logic [2:0] f3);
        outs_t o;
        o = '0;
        o.state = s;
        case (s)
            ST_FETCH:  begin o.mem_read = 1; o.src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            ST_DECODE: begin o.src_a = 2'b10; o.src_b = 2'b10; end
            ST_EXEC_R: begin o.src_a = 2'b01; o.alu_op = 2'b10; o.f7_en = 1; end
            ST_EXEC_I: begin o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 2'b10; o.f7_en = (f3 == 3'd5); end
            ST_WB_ALU: o.reg_write = 1;
            ST_ADDR:   begin o.src_a = 2'b01; o.src_b = 2'b10; end
            ST_MEM_RD: begin o.mem_read = 1; o.iord = 1; end
            ST_WB_MEM: begin o.reg_write = 1; o.mem_to_reg = 1; end
            ST_MEM_WR: begin o.mem_write = 1; o.iord = 1; end
            ST_BRANCH: begin
                o.src_a = 2'b01; o.alu_op = 2'b01; o.pc_src = 1;
                o.pc_write = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
            end
            ST_LUI:    begin o.src_b = 2'b10; o.alu_op = 2'b11; o.reg_write = 1; end
            ST_TRAP:   o.trap = 1;
            default:   ;
        endcase
        return o;
    endfunction

    // instruction-level model: DECODE expands the opcode into the remaining step list
    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            cur = ST_RESET; wcnt = 0; plan.delete();
        end else case (cur)
            ST_RESET: cur = ST_FETCH;
            ST_TRAP:  ;
            ST_FETCH, ST_MEM_RD, ST_MEM_WR:
                if (ready) begin
                    wcnt = 0;
                    if (cur == ST_FETCH) cur = ST_DECODE;
                    else cur = (plan.size() != 0) ? plan.pop_front() : ST_FETCH;
                end else if (wcnt == TO) begin
                    wcnt = 0; cur = ST_TRAP;
                end else wcnt++;
            ST_DECODE: begin
                plan.delete();
                if (opcode == 7'b0110011) plan = '{ST_EXEC_R, ST_WB_ALU};
                else if (opcode == 7'b0010011) plan = '{ST_EXEC_I, ST_WB_ALU};
                else if (opcode == 7'b0000011) plan = '{ST_ADDR, ST_MEM_RD, ST_WB_MEM};
                else if (opcode == 7'b0100011) plan = '{ST_ADDR, ST_MEM_WR};
                else if (opcode == 7'b1100011 && funct3[2:1] == 2'b00) plan = '{ST_BRANCH};
                else if (opcode == 7'b1100011) plan = '{ST_BRANCH, ST_TRAP};
                else if (opcode == 7'b0110111) plan = '{ST_LUI};
                else plan = '{ST_TRAP};
                cur = plan.pop_front();
            end
            default: cur = (plan.size() != 0) ? plan.pop_front() : ST_FETCH;
        endcase
    end

    always @(negedge clk) if (started) check("cycle_outputs", dut_outs(), expect_outs(cur, ready, zero, funct3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // runs one instruction from FETCH; MEM_RD is stalled for rd_wait cycles
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                             input int rd_wait, output int cyc);
        int w;
        w = 0;
        opcode = opc; funct3 = f3; zero = z; cyc = 0;
        do begin
            ready = !(state_o == ST_MEM_RD && w < rd_wait);
            if (!ready) w++;
            tick();
            cyc++;
        end while (state_o != ST_FETCH && state_o != ST_TRAP && cyc < 50);
    endtask

    initial begin
        tick();
        check("reset_outputs", dut_outs(), 32'h0);
        rst = 1'b0;
        tick();
        check("after_reset_state", state_o, 32'd1);
        run_instr(7'b0110011, 3'd0, 1'b0, 0, n);  check("add_latency", n, 4);
        run_instr(7'b0100011, 3'd2, 1'b0, 0, n);  check("sw_latency", n, 4);
        run_instr(7'b0110111, 3'd0, 1'b0, 0, n);  check("lui_latency", n, 3);
        run_instr(7'b1100011, 3'd1, 1'b1, 0, n);  check("bne_latency", n, 3);
        run_instr(7'b0000011, 3'd2, 1'b0, 3, n);  check("lw_3wait_latency", n, 8);
        opcode = 7'b0010011; funct3 = 3'b000; ready = 1'b1;
        tick(); tick();
        check("addi_f7_en", alu_f7_en_o, 0);
        check("addi_alu_op", alu_op_o, 2);
        tick(); tick();
        funct3 = 3'b101;
        tick(); tick();
        check("srai_f7_en", alu_f7_en_o, 1);
        tick(); tick();
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        tick(); tick();
        check("beq_taken_pcw", {pc_write_o, pc_src_o}, 2'b11);
        zero = 1'b0; #1;
        check("beq_not_taken_pcw", pc_write_o, 0);
        funct3 = 3'b001; #1;
        check("bne_taken_pcw", pc_write_o, 1);
        tick();
        run_instr(7'b1100011, 3'b100, 1'b1, 0, n);
        check("bad_funct3_trap", {state_o, trap_o}, {4'd12, 1'b1});
        check("bad_funct3_pcw_latency", n, 3);
        do_reset();
        run_instr(7'b1111111, 3'd0, 1'b0, 0, n);
        check("illegal_opcode_trap", {n[3:0], trap_o}, {4'd2, 1'b1});
        do_reset();
        ready = 1'b0; n = 0;
        do begin tick(); n++; end while (state_o != ST_TRAP && n < 40);
        check("fetch_timeout_cycles", n, 17);
        ready = 1'b1;
        repeat (5) tick();
        check("trap_sticky", trap_o, 1);
        do_reset();
        check("trap_cleared", trap_o, 0);
        opcode = 7'b0110111; ready = 1'b0;
        repeat (16) tick();
        ready = 1'b1; #1;
        check("ready_wins_at_limit", ir_write_o, 1);
        tick();
        check("ready_wins_next", state_o, 32'd2);
        tick(); tick();
        opcode = 7'b0100011;
        tick(); tick(); tick();
        ready = 1'b0;
        repeat (3) tick();
        check("held_in_mem_wr", state_o, 32'd9);
        rst = 1'b1;
        tick();
        check("reset_in_mem_wr", dut_outs(), 32'h0);
        rst = 1'b0;
        tick();
        check("fetch_after_reset", {state_o, trap_o}, {4'd1, 1'b0});
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = (cur == ST_TRAP && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
            ready = $urandom_range(0, 3) != 0;
            zero = 1'($urandom);
            if (cur == ST_FETCH) begin
                int k;
                k = $urandom_range(0, 6);
                opcode = (k < 6) ? legal[k] : 7'($urandom);
                funct3 = (opcode == 7'b1100011) ? 3'($urandom_range(0, 3)) : 3'($urandom);
            end
        end
        rst = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
